ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 16x8 data RAM between NUM_REQ requesters, e.g. CPU load/store unit (port 0) and a debug/DMA loader (port 1).
- Performs one RAM access per cycle.
- Sits between the requesters and the RAM instance inside the cpu top level.
- Uses round-robin arbitration with an optional bounded lock (burst) so one requester can own the RAM for consecutive accesses.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM data width
- MAX_BURST, 4, max consecutive locked grants to one owner before forced rotation (>=1)

Ports:
- clk  in  1  system clock, rising edge
- areset  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  access request per requester
- lock  in  NUM_REQ  hold request: keep ownership after this grant
- we  in  NUM_REQ  1 = write, 0 = read, per requester
- addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant, same cycle as req
- rvalid  out  NUM_REQ  read data valid for requester i
- rdata  out  DATA_W  registered read data, shared
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- Reset: asynchronous, active-high.
  - Clears gnt=0, rvalid=0, rdata=0, rr_ptr=0, state=IDLE, burst_cnt=0.
  - ram_we is gated low while areset=1, so no write occurs during reset.
- Grant (combinational): at most one gnt bit is high. gnt=0 when req=0.
- IDLE: winner is the first asserted req scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- LOCKED(owner): owner wins if req[owner]=1. If req[owner]=0, arbitration falls back to IDLE rules in the same cycle.
- RAM drive (combinational):
  - ram_addr and ram_wdata come from the granted requester.
  - ram_we = we[winner] & |gnt.
  - With no grant: ram_addr=0, ram_wdata=0, ram_we=0.
- Write: RAM captures on the rising edge ending the grant cycle.
- Read latency 1:
  - On a granted read, rdata <= ram_rdata at that edge.
  - rvalid[winner] is high for exactly the following cycle.
  - rdata holds its value until the next granted read.
  - Writes never raise rvalid.
- Pointer: after any grant, rr_ptr <= (winner+1) mod NUM_REQ.
- State transitions, evaluated at the clock edge:
  - IDLE -> LOCKED(w) when gnt[w] & lock[w]; burst_cnt <= 1.
  - LOCKED -> LOCKED while gnt[owner] & lock[owner] & burst_cnt < MAX_BURST-1; burst_cnt increments.
  - LOCKED -> IDLE when lock[owner]=0, req[owner]=0, or the burst limit is reached; burst_cnt <= 0.
  - On leaving LOCKED at the limit, rr_ptr already points past the owner, so a waiting requester wins next.
  - MAX_BURST=1 disables locking: state never leaves IDLE.
- Simultaneous read and write by different requesters: only the winner is serviced. Losers keep req high and retry; their inputs must stay stable until gnt.
- Back-to-back same-address accesses: a write at cycle N followed by a read at N+1 returns the new data.
- areset asserted mid-burst: immediate return to IDLE. A pending rvalid is dropped and is not reissued after reset.

Optional Feature:
- Macro ARB_CONFLICT_CNT_EN.
- Defined: adds output conflict_cnt (8 bits).
  - Increments on every cycle where at least one asserted req is not granted.
  - Saturates at 255; reset to 0.
  - Adds input conflict_clr (1 bit); synchronous clear, has priority over increment.
- Undefined: conflict_cnt and conflict_clr ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_mem_pkg: ADDR_W=4 and DATA_W=8 defaults, arb_state_t enum {ARB_IDLE, ARB_LOCKED}, MAX_BURST default constant.
- One sub-module: rr_pick.
  - Combinational rotate-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner and winner index.
  - Reused by the arbiter's IDLE path and fallback path.

Test Plan:
- Reset: areset=1 with req=2'b11 and we=2'b11 -> gnt=0, ram_we=0, rvalid=0, rdata=0; RAM contents unchanged.
- Round-robin: req=2'b11, lock=0, both reading, for 4 cycles -> gnt sequence 01,10,01,10; each rvalid pulses one cycle after its grant.
- Write then read: port1 writes 0xA5 to addr 7 at cycle N; port0 reads addr 7 at N+1 -> rdata=0xA5 with rvalid[0]=1 at N+2.
- Burst limit: MAX_BURST=4, port0 lock=1 and req held, port1 req held -> port0 granted 4 consecutive cycles, then port1 granted on the 5th.
- Lock release: port0 lock drops after 2 grants -> state returns to IDLE and port1 is granted the next cycle.
- Reset mid-burst with ARB_CONFLICT_CNT_EN defined: contention for 10 cycles, then conflict_cnt=10; areset pulse -> gnt=0, state IDLE, conflict_cnt=0; conflict_clr=1 for one cycle clears to 0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the data-RAM port arbiter and its helpers.
package cpu_mem_pkg;

  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Index width for a requester number; at least one bit even for two requesters.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotate-priority encoder: first asserted request at or above rr_ptr_i, wrapping.
module rr_pick
  import cpu_mem_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((32'(rr_ptr_i) + k) % 32'(NUM_REQ));
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded lock for the shared 16x8 data RAM.
// Optional conflict counter ports/logic enabled by defining ARB_CONFLICT_CNT_EN.
module ram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
`ifdef ARB_CONFLICT_CNT_EN
  ,
  input  logic                      conflict_clr,
  output logic [7:0]                conflict_cnt
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t          state_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic [CNT_W-1:0]    burst_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                any_gnt;
  logic                owner_hold;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // A locked owner that stops requesting falls through to plain round-robin this cycle.
  always_comb begin
    owner_hold = (state_q == ARB_LOCKED) && req[owner_q];
    gnt_oh     = '0;
    win_idx    = '0;
    any_gnt    = 1'b0;
    if (!areset) begin
      if (owner_hold) begin
        gnt_oh[owner_q] = 1'b1;
        win_idx         = owner_q;
        any_gnt         = 1'b1;
      end else begin
        gnt_oh  = pick_oh;
        win_idx = pick_idx;
        any_gnt = pick_any;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        ram_we    = we[i];
        ram_addr  = addr[i*ADDR_W +: ADDR_W];
        ram_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_ptr_d = IDX_W'((32'(win_idx) + 32'd1) % 32'(NUM_REQ));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      burst_q  <= '0;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (any_gnt) begin
        rr_ptr_q <= rr_ptr_d;
        if (!we[win_idx]) begin
          rvalid_q[win_idx] <= 1'b1;
          rdata_q           <= ram_rdata;
        end
      end
      case (state_q)
        ARB_IDLE: begin
          if (any_gnt && lock[win_idx] && MAX_BURST > 1) begin
            state_q <= ARB_LOCKED;
            owner_q <= win_idx;
            burst_q <= CNT_W'(1);
          end
        end
        ARB_LOCKED: begin
          if (gnt_oh[owner_q] && lock[owner_q] && int'(burst_q) < MAX_BURST - 1) begin
            burst_q <= burst_q + CNT_W'(1);
          end else begin
            state_q <= ARB_IDLE;
            burst_q <= '0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          burst_q <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_oh;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

`ifdef ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      conflict_q <= '0;
    end else if (conflict_clr) begin
      conflict_q <= '0;
    end else if (|(req & ~gnt_oh) && conflict_q != '1) begin
      conflict_q <= conflict_q + 8'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 16x8 RAM attached.
module tb_ram_port_arbiter;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] we;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] egnt;
    logic       ewe;
    logic [7:0] erd;
    logic       chk;
  } vec_t;

  typedef struct packed {
    logic [1:0] g;
    logic       w;
  } gexp_t;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } rexp_t;

  logic       clk = 1'b0;
  logic       areset;
  logic [1:0] req, lock, we;
  logic [7:0] addr;
  logic [15:0] wdata;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       init_mem;
  logic [7:0] mem [16];
`ifdef ARB_CONFLICT_CNT_EN
  logic       conflict_clr;
  logic [7:0] conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;
  gexp_t gnt_q[$];
  rexp_t rd_q[$];

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_REQ   (2),
    .ADDR_W    (4),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef ARB_CONFLICT_CNT_EN
    ,
    .conflict_clr (conflict_clr),
    .conflict_cnt (conflict_cnt)
`endif
  );

  assign ram_rdata = mem[ram_addr];

  always_ff @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h30 + i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    req   = v.req;
    lock  = v.lock;
    we    = v.we;
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
    gnt_q.push_back('{g: v.egnt, w: v.ewe});
    if (v.chk && v.egnt != 2'b00 && !v.ewe)
      rd_q.push_back('{port: v.egnt, data: v.erd});
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idle_vec();
    return '{req: 2'b00, lock: 2'b00, we: 2'b00, a0: 4'h0, a1: 4'h0, d0: 8'h00, d1: 8'h00,
             egnt: 2'b00, ewe: 1'b0, erd: 8'h00, chk: 1'b1};
  endfunction

  function automatic vec_t cont_vec(input logic [1:0] g);
    return '{req: 2'b11, lock: 2'b00, we: 2'b00, a0: 4'h0, a1: 4'h1, d0: 8'h00, d1: 8'h00,
             egnt: g, ewe: 1'b0, erd: (g == 2'b01) ? 8'h30 : 8'h31, chk: 1'b1};
  endfunction

  // req lock we a0 a1 d0 d1 | egnt ewe erd chk  (RAM preloaded with 0x30+addr)
  vec_t main_v [23] = '{
    '{2'b11, 2'b00, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b01, 1'b0, 8'h31, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b10, 1'b0, 8'h32, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b01, 1'b0, 8'h31, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b10, 1'b0, 8'h32, 1'b1},
    '{2'b10, 2'b00, 2'b10, 4'h0, 4'h7, 8'h00, 8'hA5, 2'b10, 1'b1, 8'h00, 1'b1},
    '{2'b01, 2'b00, 2'b00, 4'h7, 4'h0, 8'h00, 8'h00, 2'b01, 1'b0, 8'hA5, 1'b1},
    '{2'b10, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b10, 1'b0, 8'h30, 1'b1},
    '{2'b11, 2'b01, 2'b00, 4'h4, 4'h5, 8'h00, 8'h00, 2'b01, 1'b0, 8'h34, 1'b1},
    '{2'b11, 2'b01, 2'b00, 4'h4, 4'h5, 8'h00, 8'h00, 2'b01, 1'b0, 8'h34, 1'b1},
    '{2'b11, 2'b01, 2'b01, 4'h4, 4'h5, 8'h5A, 8'h00, 2'b01, 1'b1, 8'h00, 1'b1},
    '{2'b11, 2'b01, 2'b00, 4'h4, 4'h5, 8'h00, 8'h00, 2'b01, 1'b0, 8'h5A, 1'b1},
    '{2'b11, 2'b01, 2'b00, 4'h4, 4'h5, 8'h00, 8'h00, 2'b10, 1'b0, 8'h35, 1'b1},
    '{2'b11, 2'b01, 2'b00, 4'h6, 4'h8, 8'h00, 8'h00, 2'b01, 1'b0, 8'h36, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'h6, 4'h8, 8'h00, 8'h00, 2'b01, 1'b0, 8'h36, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'h6, 4'h8, 8'h00, 8'h00, 2'b10, 1'b0, 8'h38, 1'b1},
    '{2'b11, 2'b01, 2'b00, 4'h6, 4'h8, 8'h00, 8'h00, 2'b01, 1'b0, 8'h36, 1'b1},
    '{2'b10, 2'b00, 2'b10, 4'h6, 4'h9, 8'h00, 8'hC3, 2'b10, 1'b1, 8'h00, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'h9, 4'h9, 8'h00, 8'h00, 2'b01, 1'b0, 8'hC3, 1'b1},
    '{2'b11, 2'b00, 2'b01, 4'hA, 4'hA, 8'h77, 8'h00, 2'b10, 1'b0, 8'h3A, 1'b1},
    '{2'b11, 2'b00, 2'b01, 4'hA, 4'hA, 8'h77, 8'h00, 2'b01, 1'b1, 8'h00, 1'b1},
    '{2'b10, 2'b00, 2'b00, 4'hA, 4'hA, 8'h00, 8'h00, 2'b10, 1'b0, 8'h77, 1'b1},
    '{2'b00, 2'b00, 2'b00, 4'hA, 4'hA, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1},
    '{2'b10, 2'b10, 2'b00, 4'h0, 4'hB, 8'h00, 8'h00, 2'b10, 1'b0, 8'h3B, 1'b0}
  };

  // After a reset taken while port 1 held the lock: pointer and state start fresh.
  vec_t post_v [3] = '{
    '{2'b11, 2'b00, 2'b00, 4'hC, 4'hD, 8'h00, 8'h00, 2'b01, 1'b0, 8'h3C, 1'b1},
    '{2'b11, 2'b00, 2'b00, 4'hC, 4'hD, 8'h00, 8'h00, 2'b10, 1'b0, 8'h3D, 1'b1},
    '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1}
  };

  initial begin : monitor
    gexp_t ge;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (gnt_q.size() > 0) begin
        ge = gnt_q.pop_front();
        check("gnt", 32'(gnt), 32'(ge.g));
        check("ram_we", 32'(ram_we), 32'(ge.w));
        if (ge.g == 2'b00) begin
          check("idle_ram_addr", 32'(ram_addr), 32'h0);
          check("idle_ram_wdata", 32'(ram_wdata), 32'h0);
        end
      end
      if (rvalid != 2'b00) begin
        if (rd_q.size() == 0) begin
          check("unexpected_rvalid", 32'(rvalid), 32'h0);
        end else begin
          re = rd_q.pop_front();
          check("rvalid", 32'(rvalid), 32'(re.port));
          check("rdata", 32'(rdata), 32'(re.data));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : driver
    areset   = 1'b1;
    init_mem = 1'b1;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
`ifdef ARB_CONFLICT_CNT_EN
    conflict_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    req   = 2'b11;
    we    = 2'b11;
    addr  = {4'h3, 4'h2};
    wdata = {8'hEE, 8'hFF};
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_mem2", 32'(mem[2]), 32'h32);
    check("rst_mem3", 32'(mem[3]), 32'h33);
    req = '0; we = '0; addr = '0; wdata = '0;
    areset = 1'b0;

    foreach (main_v[i]) run_vec(main_v[i]);

    // Reset lands while the last read's rvalid is pending; that pulse must vanish.
    req = 2'b11; we = 2'b11;
    areset = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_ram_we", 32'(ram_we), 32'h0);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_rdata", 32'(rdata), 32'h0);
    @(posedge clk);
    #1;
    req = '0; we = '0;
    areset = 1'b0;
    check("midrst_mem7", 32'(mem[7]), 32'hA5);

    foreach (post_v[i]) run_vec(post_v[i]);

`ifdef ARB_CONFLICT_CNT_EN
    conflict_clr = 1'b1;
    run_vec(idle_vec());
    conflict_clr = 1'b0;
    check("cc_clear0", 32'(conflict_cnt), 32'h0);
    for (int i = 0; i < 10; i++) run_vec(cont_vec((i % 2 == 0) ? 2'b01 : 2'b10));
    check("cc_ten", 32'(conflict_cnt), 32'd10);
    run_vec(idle_vec());
    check("cc_hold", 32'(conflict_cnt), 32'd10);
    areset = 1'b1;
    #1;
    check("cc_rst", 32'(conflict_cnt), 32'h0);
    check("cc_rst_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    run_vec(cont_vec(2'b01));
    run_vec(cont_vec(2'b10));
    run_vec(cont_vec(2'b01));
    check("cc_three", 32'(conflict_cnt), 32'd3);
    conflict_clr = 1'b1;
    run_vec(cont_vec(2'b10));
    conflict_clr = 1'b0;
    check("cc_clr_prio", 32'(conflict_cnt), 32'h0);
    run_vec(idle_vec());
`endif

    run_vec(idle_vec());
    run_vec(idle_vec());
    check("gnt_q_drained", 32'(gnt_q.size()), 32'h0);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
